// File: rtl/conv_encoder_framer.sv
// conv_encoder_framer: rate-1/2 K=3 (G0=7, G1=5) convolutional encoder that frames FRAME_LEN data bits
// followed by two zero tail bits. It has a one-deep registered symbol output with valid/ready handshake.
module conv_encoder_framer #(
  parameter int FRAME_LEN = 8,
  parameter int CNT_W     = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       din,
  input  logic       din_valid,
  output logic       din_ready,
  output logic [1:0] sym_out,
  output logic       sym_valid,
  input  logic       sym_ready,
  output logic       busy,
  output logic       frame_done
);
  typedef enum logic [1:0] {IDLE, DATA, TAIL} state_t;
  state_t r_state, w_next;
  logic [1:0] r_s, r_tcnt, r_sym;
  logic [CNT_W-1:0] r_cnt;
  logic r_vld, w_free, w_load_d, w_load_t, w_load, w_u, w_last_bit;
  assign w_free     = !r_vld || sym_ready;
  assign din_ready  = (r_state == DATA) && w_free;
  assign w_load_d   = din_valid && din_ready;
  assign w_load_t   = (r_state == TAIL) && (r_tcnt != 2'd2) && w_free;
  assign w_load     = w_load_d || w_load_t;
  assign w_u        = w_load_d && din;
  assign w_last_bit = r_cnt == CNT_W'(FRAME_LEN - 1);
  // r_tcnt==2 means both tail symbols are loaded; the frame ends when the last one is accepted
  assign frame_done = (r_state == TAIL) && (r_tcnt == 2'd2) && r_vld && sym_ready;
  assign sym_out    = r_sym;
  assign sym_valid  = r_vld;
  assign busy       = r_state != IDLE;
  always_comb begin
    w_next = r_state;
    w_next = (r_state == IDLE && start) ? DATA :
             (w_load_d && w_last_bit)   ? TAIL :
             frame_done                 ? IDLE : r_state;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_s     <= '0;
      r_cnt   <= '0;
      r_tcnt  <= '0;
      r_sym   <= '0;
      r_vld   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && start) begin
        r_s    <= '0;
        r_cnt  <= '0;
        r_tcnt <= '0;
      end
      if (w_load) begin
        r_sym <= {w_u ^ r_s[1] ^ r_s[0], w_u ^ r_s[0]};
        r_vld <= 1'b1;
        r_s   <= {w_u, r_s[1]};
      end else if (sym_ready) r_vld <= 1'b0;
      if (w_load_d) r_cnt <= w_last_bit ? '0 : r_cnt + 1'b1;
      if (w_load_t) r_tcnt <= r_tcnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_conv_encoder_framer.sv
// tb_conv_encoder_framer: random-stimulus scoreboard bench for conv_encoder_framer.
// A reference encoder computes expected symbols from whole-frame bit arrays.
module tb_conv_encoder_framer;
  localparam int N = 8;
  logic clk = 0, rst = 0, start = 0, din = 0, din_valid = 0, sym_ready = 0;
  logic din_ready, sym_valid, busy, frame_done;
  logic [1:0] sym_out;
  typedef struct packed {logic [1:0] sym; logic last;} exp_t;
  exp_t q[$];
  int checks = 0, passes = 0;
  int rdy_mode = 0;

  conv_encoder_framer #(.FRAME_LEN(N), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .sym_out(sym_out), .sym_valid(sym_valid), .sym_ready(sym_ready), .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    sym_ready = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? 1'($urandom) : 1'b0;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s got=%0h expected=%0h at %0t", name, act, exp, $time);
  endtask

  task automatic timeout(input string name, input int n);
    checks++;
    $display("FAIL timeout_%s waited=%0d cycles expected=event", name, n);
  endtask

  // Each symbol k uses bits b[k], b[k-1], b[k-2] of the frame extended by two zero tail bits
  task automatic push_ref(input logic [N-1:0] d);
    logic [N+1:0] b;
    logic u, u1, u2;
    b = {2'b00, d};
    for (int k = 0; k < N + 2; k++) begin
      u  = b[k];
      u1 = (k >= 1) ? b[k-1] : 1'b0;
      u2 = (k >= 2) ? b[k-2] : 1'b0;
      q.push_back({u ^ u1 ^ u2, u ^ u2, k == N + 1});
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      if (sym_valid && sym_ready) begin
        if (q.size() == 0) begin
          checks++;
          $display("FAIL unexpected_sym got=%b expected=none", sym_out);
        end else begin
          e = q.pop_front();
          chk("sym_out", 32'(sym_out), 32'(e.sym));
          chk("frame_done_on_accept", 32'(frame_done), 32'(e.last));
        end
      end else chk("frame_done_no_accept", 32'(frame_done), 0);
    end
  end

  task automatic do_start();
    int n = 0;
    while (busy && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) timeout("idle_before_start", n);
    @(posedge clk); #1;
    start = 1;
    @(posedge clk); #1;
    start = 0;
  endtask

  task automatic send(input logic [N-1:0] d, input int gap_pct, input int nbits);
    logic acc;
    int n;
    for (int i = 0; i < nbits; i++) begin
      while ($urandom_range(0, 99) < gap_pct) begin
        din_valid = 0;
        din = 1'($urandom);
        @(posedge clk); #1;
      end
      din = d[i];
      din_valid = 1;
      n = 0;
      do begin
        @(negedge clk);
        acc = din_ready;
        @(posedge clk); #1;
        n++;
      end while (!acc && n < 200);
      if (!acc) timeout("din_accept", n);
    end
    din_valid = 0;
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin @(negedge clk); n++; end while ((busy || q.size() != 0) && n < 500);
    if (n >= 500) timeout("frame_end", n);
  endtask

  task automatic frame(input logic [N-1:0] d, input int gap_pct);
    push_ref(d);
    do_start();
    send(d, gap_pct, N);
    wait_idle();
  endtask

  initial begin
    logic [N-1:0] d;
    int n;
    #1;
    chk("rst_sym_valid", 32'(sym_valid), 0);
    chk("rst_sym_out", 32'(sym_out), 0);
    chk("rst_din_ready", 32'(din_ready), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_frame_done", 32'(frame_done), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1;
    repeat (3) @(posedge clk);
    #1 chk("idle_until_start", 32'(busy), 0);

    frame(8'hFF, 0);
    frame(8'h01, 0);

    // Downstream stall right after the first symbol
    rdy_mode = 2;
    push_ref(8'hA5);
    do_start();
    fork
      send(8'hA5, 0, N);
      begin
        n = 0;
        do begin @(negedge clk); n++; end while (!sym_valid && n < 50);
        if (n >= 50) timeout("first_sym", n);
        for (int i = 0; i < 3; i++) begin
          chk("stall_sym_hold", 32'(sym_out), 32'(q[0].sym));
          chk("stall_valid_hold", 32'(sym_valid), 1);
          chk("stall_din_ready", 32'(din_ready), 0);
          @(negedge clk);
        end
        rdy_mode = 0;
      end
    join
    wait_idle();

    rdy_mode = 1;
    for (int i = 0; i < 6; i++) frame(8'($urandom), 40);
    rdy_mode = 0;

    // start held through DATA/TAIL and in the frame_done cycle must be ignored
    d = 8'($urandom);
    push_ref(d);
    do_start();
    start = 1;
    send(d, 0, N);
    n = 0;
    do begin @(negedge clk); n++; end while (!frame_done && n < 100);
    if (n >= 100) timeout("frame_done", n);
    @(posedge clk); #1;
    start = 0;
    chk("start_in_done_ignored", 32'(busy), 0);
    d = 8'($urandom);
    push_ref(d);
    start = 1;
    @(posedge clk); #1;
    start = 0;
    chk("start_after_done", 32'(busy), 1);
    send(d, 0, N);
    wait_idle();

    // Asynchronous reset mid-frame discards the frame
    push_ref(8'hF3);
    do_start();
    send(8'hF3, 0, 4);
    #2 rst = 0;
    #1;
    chk("mid_rst_sym_valid", 32'(sym_valid), 0);
    chk("mid_rst_sym_out", 32'(sym_out), 0);
    chk("mid_rst_din_ready", 32'(din_ready), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_frame_done", 32'(frame_done), 0);
    q.delete();
    @(posedge clk); #1 rst = 1;
    repeat (2) @(posedge clk);
    #1 chk("idle_after_mid_rst", 32'(busy), 0);
    frame(8'h3C, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/conv_encoder_framer.md
CONV_ENCODER_FRAMER -- requirements
Module: conv_encoder_framer

Interface
REQ-001 The block SHALL have parameter FRAME_LEN, default 8, giving the number of data bits per frame (legal range 1..2**CNT_W-1).
REQ-002 The block SHALL have parameter CNT_W, default 4, giving the width of the data-bit counter.
REQ-003 clk  input  1  single clock; all state is updated on the rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  single-cycle request to begin a frame; honoured only in IDLE.
REQ-006 din  input  1  serial data bit.
REQ-007 din_valid  input  1  din is valid.
REQ-008 din_ready  output  1  block accepts din this cycle.
REQ-009 sym_out  output  2  encoded symbol, {G0 bit, G1 bit}; this is the decoder's dec_in.
REQ-010 sym_valid  output  1  sym_out holds a valid symbol.
REQ-011 sym_ready  input  1  downstream accepts sym_out this cycle.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 frame_done  output  1  one-cycle pulse when the last tail symbol is accepted downstream.

Function
REQ-014 Encoding SHALL be rate 1/2, K=3, with 2-bit state {s1,s0}, where s1 = u(n-1) and s0 = u(n-2).
REQ-015 For each input bit u, the symbol SHALL be sym_out[1] = u^s1^s0 (G0=7 octal) and sym_out[0] = u^s0 (G1=5 octal).
REQ-016 On each encoded bit, the state SHALL update as s0<=s1, s1<=u.
REQ-017 The FSM SHALL have states IDLE, DATA and TAIL.
REQ-018 In IDLE with start=1, the block SHALL clear {s1,s0} and the bit counter and enter DATA on the next cycle.
REQ-019 start SHALL be ignored outside IDLE.
REQ-020 Output slot free SHALL be defined as slot_free = !sym_valid || sym_ready.
REQ-021 din_ready SHALL equal (state==DATA) && slot_free, combinationally.
REQ-022 On din_valid && din_ready, the block SHALL register the symbol into sym_out, set sym_valid, update the state and increment the counter; latency from din accept to sym_valid is 1 cycle.
REQ-023 sym_out and sym_valid SHALL hold stable while sym_valid && !sym_ready.
REQ-024 With continuous valid/ready on both sides, throughput SHALL be one symbol per cycle with no bubbles.
REQ-025 If sym_ready=1 and no new symbol is loaded, sym_valid SHALL clear on the next edge.
REQ-026 When the FRAME_LEN-th bit is accepted, the FSM SHALL enter TAIL.
REQ-027 In TAIL, the block SHALL encode two u=0 tail bits, each loaded only when slot_free, returning the state to 00.
REQ-028 In TAIL, din_ready SHALL be 0.
REQ-029 After the second tail symbol is loaded, the FSM SHALL remain in TAIL until that symbol is accepted (sym_valid && sym_ready), then enter IDLE.
REQ-030 frame_done SHALL be high in exactly the acceptance cycle of REQ-029.
REQ-031 A new start is honoured no earlier than the cycle after the return to IDLE, so frames never overlap.
REQ-032 The bit counter SHALL count 0..FRAME_LEN-1 and never wrap within a frame.
REQ-033 din_valid with din_ready=0 SHALL have no effect, and no bit is lost or duplicated.

Reset
REQ-034 While rst=0, the block SHALL immediately force: state=IDLE, {s1,s0}=00, counter=0, sym_out=00, sym_valid=0, din_ready=0, busy=0, frame_done=0.
REQ-035 Reset asserted mid-frame SHALL discard the frame; no frame_done is produced for it.
REQ-036 After rst deasserts, the block SHALL stay in IDLE until start.

Verification
REQ-037 The bench SHALL cover: FRAME_LEN=8, din all ones, sym_ready=1 -> sym_out 11,01,10,10,10,10,10,10,01,11, then frame_done on the 10th accept.
REQ-038 The bench SHALL cover: impulse 1,0,0,0,0,0,0,0 -> sym_out 11,10,11,00,00,00,00,00,00,00.
REQ-039 The bench SHALL cover: sym_ready held 0 for 3 cycles after the first symbol -> sym_out held, din_ready=0, no input consumed; the sequence resumes unchanged.
REQ-040 The bench SHALL cover: din_valid toggling 1/0 randomly -> the symbol sequence equals the gap-free reference for the same data.
REQ-041 The bench SHALL cover: rst pulled low after 4 data bits -> all outputs 0 asynchronously; the next start produces a fresh frame from state 00.
REQ-042 The bench SHALL cover: start asserted during DATA/TAIL -> ignored; start in the frame_done cycle -> ignored; start one cycle later -> new frame.
